pulse_gen: RTL and testbench

PULSE_GEN -- requirements
Module: pulse_gen

---
 rtl/pulse_gen_pkg.sv | 12 +
 rtl/pulse_gen_ch.sv | 143 ++++++++++++++
 rtl/pulse_gen.sv | 46 ++++
 tb/tb_pulse_gen.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/pulse_gen_pkg.sv
// Shared definitions for the pulse generator: channel FSM encoding and default sizing.
package pulse_gen_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam int DEF_CH = 4;
    localparam int DEF_CW = 8;

endpackage

// File: rtl/pulse_gen_ch.sv
// One pulse generator channel: latches P/W/mode at start and runs a (P+1)-cycle period.
// Outputs are registered one cycle ahead of the counter, so wrap/done coincide with count==P.
module pulse_gen_ch
    import pulse_gen_pkg::*;
#(
    parameter int CW = DEF_CW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          stop,
    input  logic          mode,
    input  logic [CW-1:0] period,
    input  logic [CW-1:0] width,
`ifdef PULSE_GEN_BURST_EN
    input  logic [CW-1:0] burst_len,
`endif
    output logic          pulse,
    output logic          wrap,
    output logic          busy,
    output logic          done
);

    state_t        state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] p_q, p_d;
    logic [CW-1:0] w_q, w_d;
    logic          mode_q, mode_d;
    logic          pulse_q, pulse_d;
    logic          wrap_q, wrap_d;
    logic          done_q, done_d;
    logic          period_end;
    logic          last_now;
    logic          last_next;
    logic          last_at_start;
    logic          finish;

`ifdef PULSE_GEN_BURST_EN
    logic [CW-1:0] pcnt_q, pcnt_d;
    logic [CW-1:0] burst_q, burst_d;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            p_q     <= '0;
            w_q     <= '0;
            mode_q  <= 1'b0;
            pulse_q <= 1'b0;
            wrap_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef PULSE_GEN_BURST_EN
            pcnt_q  <= '0;
            burst_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            p_q     <= p_d;
            w_q     <= w_d;
            mode_q  <= mode_d;
            pulse_q <= pulse_d;
            wrap_q  <= wrap_d;
            done_q  <= done_d;
`ifdef PULSE_GEN_BURST_EN
            pcnt_q  <= pcnt_d;
            burst_q <= burst_d;
`endif
        end
    end

    assign period_end = (count_q == p_q);

    // "last" means the current (or upcoming) period is the final one of a one-shot run.
`ifdef PULSE_GEN_BURST_EN
    assign last_now      = (pcnt_q == burst_q);
    assign last_at_start = (burst_len == '0);
    assign last_next     = (pcnt_d == burst_q);
`else
    assign last_now      = 1'b1;
    assign last_at_start = 1'b1;
    assign last_next     = 1'b1;
`endif

    assign finish = (state_q == ST_RUN) && mode_q && period_end && last_now;

    always_comb begin
        state_d = state_q;
        if (stop) begin
            state_d = ST_IDLE;
        end else if (start) begin
            state_d = ST_RUN;
        end else if (finish) begin
            state_d = ST_IDLE;
        end
    end

    always_comb begin
        count_d = count_q;
        p_d     = p_q;
        w_d     = w_q;
        mode_d  = mode_q;
        pulse_d = 1'b0;
        wrap_d  = 1'b0;
        done_d  = 1'b0;
`ifdef PULSE_GEN_BURST_EN
        pcnt_d  = pcnt_q;
        burst_d = burst_q;
`endif
        if (stop) begin
            count_d = count_q;
        end else if (start) begin
            p_d     = period;
            w_d     = width;
            mode_d  = mode;
            count_d = '0;
`ifdef PULSE_GEN_BURST_EN
            pcnt_d  = '0;
            burst_d = burst_len;
`endif
            pulse_d = (width != '0);
            wrap_d  = (period == '0);
            done_d  = mode && (period == '0) && last_at_start;
        end else if ((state_q == ST_RUN) && !finish) begin
            count_d = period_end ? '0 : count_q + 1'b1;
`ifdef PULSE_GEN_BURST_EN
            pcnt_d  = period_end ? pcnt_q + 1'b1 : pcnt_q;
`endif
            pulse_d = (count_d < w_q);
            wrap_d  = (count_d == p_q);
            done_d  = mode_q && wrap_d && last_next;
        end
    end

    always_comb begin
        pulse = pulse_q;
        wrap  = wrap_q;
        busy  = (state_q == ST_RUN);
        done  = done_q;
    end

endmodule

// File: rtl/pulse_gen.sv
// CH-channel programmable pulse generator; each channel is an independent pulse_gen_ch.
// Define PULSE_GEN_BURST_EN to add burst_len (one-shot runs burst_len+1 periods).
module pulse_gen
    import pulse_gen_pkg::*;
#(
    parameter int CH = DEF_CH,
    parameter int CW = DEF_CW
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [CH-1:0]    start,
    input  logic [CH-1:0]    stop,
    input  logic [CH-1:0]    mode,
    input  logic [CH*CW-1:0] period,
    input  logic [CH*CW-1:0] width,
`ifdef PULSE_GEN_BURST_EN
    input  logic [CH*CW-1:0] burst_len,
`endif
    output logic [CH-1:0]    pulse,
    output logic [CH-1:0]    wrap,
    output logic [CH-1:0]    busy,
    output logic [CH-1:0]    done
);

    for (genvar i = 0; i < CH; i++) begin : g_ch
        pulse_gen_ch #(
            .CW(CW)
        ) u_ch (
            .clk      (clk),
            .reset    (reset),
            .start    (start[i]),
            .stop     (stop[i]),
            .mode     (mode[i]),
            .period   (period[i*CW +: CW]),
            .width    (width[i*CW +: CW]),
`ifdef PULSE_GEN_BURST_EN
            .burst_len(burst_len[i*CW +: CW]),
`endif
            .pulse    (pulse[i]),
            .wrap     (wrap[i]),
            .busy     (busy[i]),
            .done     (done[i])
        );
    end

endmodule

// File: tb/tb_pulse_gen.sv
// Directed bench for pulse_gen (CH=4, CW=8) with hand-derived per-cycle expectations.
module tb_pulse_gen;

    localparam int CH = 4;
    localparam int CW = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic [CH-1:0]    start, stop, mode;
    logic [CH*CW-1:0] period, width;
`ifdef PULSE_GEN_BURST_EN
    logic [CH*CW-1:0] burst_len;
`endif
    logic [CH-1:0]    pulse, wrap, busy, done;

    int n_chk  = 0;
    int n_pass = 0;

    pulse_gen #(.CH(CH), .CW(CW)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .stop     (stop),
        .mode     (mode),
        .period   (period),
        .width    (width),
`ifdef PULSE_GEN_BURST_EN
        .burst_len(burst_len),
`endif
        .pulse    (pulse),
        .wrap     (wrap),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".pulse"}, 32'(pulse), 32'h0);
        chk({tag, ".wrap"},  32'(wrap),  32'h0);
        chk({tag, ".busy"},  32'(busy),  32'h0);
        chk({tag, ".done"},  32'(done),  32'h0);
    endtask

    initial begin
        logic [CH-1:0] ep, ew, eb, ed;
        reset  = 1'b1;
        start  = '0;
        stop   = '0;
        mode   = '0;
        period = '0;
        width  = '0;
`ifdef PULSE_GEN_BURST_EN
        burst_len = '0;
`endif
        tick();
        tick();
        chk_idle("reset");
        reset = 1'b0;
        tick();

        // All four channels started together: ch0 cont P5 W1, ch1 one-shot P3 W2,
        // ch2 cont P5 W0, ch3 cont P5 W9.
        period = {8'd5, 8'd5, 8'd3, 8'd5};
        width  = {8'd9, 8'd0, 8'd2, 8'd1};
        mode   = 4'b0010;
        start  = 4'b1111;
        tick();
        start  = '0;
        period = {CH{8'd1}};
        width  = '0;
        mode   = 4'b1101;
        for (int c = 1; c <= 14; c++) begin
            ep = {1'b1, 1'b0, (c <= 2), (c % 6 == 1)};
            ew = {(c % 6 == 0), (c % 6 == 0), (c == 4), (c % 6 == 0)};
            eb = {1'b1, 1'b1, (c <= 4), 1'b1};
            ed = {1'b0, 1'b0, (c == 4), 1'b0};
            chk($sformatf("main.pulse c%0d", c), 32'(pulse), 32'(ep));
            chk($sformatf("main.wrap c%0d", c),  32'(wrap),  32'(ew));
            chk($sformatf("main.busy c%0d", c),  32'(busy),  32'(eb));
            chk($sformatf("main.done c%0d", c),  32'(done),  32'(ed));
            tick();
        end

        stop = 4'b1111;
        tick();
        stop = '0;
        chk_idle("stop");

        // start and stop together while idle, then while running
        start = 4'b0001;
        stop  = 4'b0001;
        tick();
        chk("startstop_idle.busy", 32'(busy), 32'h0);
        period = {4{8'd5}};
        width  = {4{8'd1}};
        mode   = '0;
        stop   = '0;
        tick();
        start  = '0;
        chk("run_before_stop.busy", 32'(busy), 32'h1);
        start = 4'b0001;
        stop  = 4'b0001;
        tick();
        start = '0;
        stop  = '0;
        chk("startstop_run.busy", 32'(busy), 32'h0);
        tick();
        chk("startstop_run.busy2", 32'(busy), 32'h0);

        // one-shot P5 W2 on ch1, restarted at count 3
        period = {4{8'd5}};
        width  = {4{8'd2}};
        mode   = 4'b0010;
        start  = 4'b0010;
        tick();
        start  = '0;
        tick();
        tick();
        tick();
        chk("restart.pre_busy", 32'(busy), 32'h2);
        start = 4'b0010;
        tick();
        start = '0;
        for (int n = 1; n <= 6; n++) begin
            chk($sformatf("restart.pulse n%0d", n), 32'(pulse[1]), 32'(n <= 2));
            chk($sformatf("restart.done n%0d", n),  32'(done[1]),  32'(n == 6));
            chk($sformatf("restart.wrap n%0d", n),  32'(wrap[1]),  32'(n == 6));
            tick();
        end
        chk("restart.busy_after", 32'(busy), 32'h0);
        chk("restart.done_after", 32'(done), 32'h0);

        // P=0 on ch2 (wrap every cycle), plus ch0 continuous, then reset mid-run
        period = {8'd0, 8'd0, 8'd0, 8'd5};
        width  = {8'd0, 8'd1, 8'd0, 8'd1};
        mode   = '0;
        start  = 4'b0101;
        tick();
        start  = '0;
        for (int c = 1; c <= 3; c++) begin
            chk($sformatf("p0.wrap c%0d", c),  32'(wrap[2]),  32'h1);
            chk($sformatf("p0.pulse c%0d", c), 32'(pulse[2]), 32'h1);
            chk($sformatf("p0.busy c%0d", c),  32'(busy),     32'h5);
            tick();
        end
        reset = 1'b1;
        start = 4'b1111;
        stop  = 4'b1111;
        tick();
        chk_idle("midreset");
        reset = 1'b0;
        start = '0;
        stop  = '0;
        tick();
        chk_idle("post_reset");

`ifdef PULSE_GEN_BURST_EN
        period    = {4{8'd1}};
        width     = {4{8'd1}};
        burst_len = {4{8'd2}};
        mode      = 4'b0010;
        start     = 4'b0010;
        tick();
        start     = '0;
        for (int c = 1; c <= 7; c++) begin
            chk($sformatf("burst.pulse c%0d", c), 32'(pulse[1]), 32'(c == 1 || c == 3 || c == 5));
            chk($sformatf("burst.done c%0d", c),  32'(done[1]),  32'(c == 6));
            chk($sformatf("burst.busy c%0d", c),  32'(busy[1]),  32'(c <= 6));
            tick();
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
